ft_recovery: RTL and testbench

//  Rollback sequencer for the dual-core lockstep pair. On a write mismatch flagged by
//  the error checker, it holds fetch on both cores and reads every entry of the

---
 rtl/ft_recovery.sv | 129 ++++++++++++
 tb/tb_ft_recovery.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft_recovery.sv
// Rollback sequencer for a dual-core lockstep pair: on a mismatch it halts fetch, copies the
// golden register file back into both cores and restores the saved PC.
module ft_recovery #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 2**ADDR_WIDTH,
    parameter int DRAIN_CYC  = 3,
    parameter bit SKIP_R0    = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  error_i,
    input  logic [DATA_WIDTH-1:0] spc_i,
    output logic [ADDR_WIDTH-1:0] rf_raddr_o,
    output logic                  rf_re_o,
    input  logic [DATA_WIDTH-1:0] rf_rdata_i,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] waddr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic                  fetch_block_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic                  pc_valid_o,
    input  logic                  pc_ack_i,
    output logic                  busy_o,
    output logic [7:0]            rec_count_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_HALT, S_COPY, S_FLUSH, S_PC, S_RESUME
    } state_t;

    localparam int CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(DRAIN_CYC - 1);
    localparam logic [ADDR_WIDTH-1:0] PTR_FIRST = ADDR_WIDTH'(SKIP_R0);
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST  = '1;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        drain_cnt;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic                    rd_pending;
    logic [ADDR_WIDTH-1:0]   waddr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   pc_q;
    logic [7:0]              rec_count;

    // NOTE: state is updated with non-blocking assignments and reset asynchronously, so an
    // abort takes effect without waiting for a clock edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_nxt     = state;
        rf_re_o       = 1'b0;
        fetch_block_o = 1'b0;
        pc_valid_o    = 1'b0;
        busy_o        = 1'b1;
        case (state)
            S_IDLE: begin
                busy_o = 1'b0;
                if (error_i) state_nxt = S_HALT;
            end
            S_HALT: begin
                fetch_block_o = 1'b1;
                if (drain_cnt == CNT_LAST) state_nxt = S_COPY;
            end
            S_COPY: begin
                fetch_block_o = 1'b1;
                rf_re_o       = 1'b1;
                if (ptr == PTR_LAST) state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                fetch_block_o = 1'b1;
                state_nxt     = S_PC;
            end
            S_PC: begin
                fetch_block_o = 1'b1;
                pc_valid_o    = 1'b1;
                if (pc_ack_i) state_nxt = S_RESUME;
            end
            S_RESUME: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Write-back trails the read by one cycle: the golden RF returns data the cycle after rf_re_o.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            drain_cnt  <= '0;
            ptr        <= '0;
            rd_pending <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            pc_q       <= '0;
            rec_count  <= '0;
        end else begin
            rd_pending <= (state == S_COPY);
            if (rd_pending) wdata_q <= rf_rdata_i;
            case (state)
                S_IDLE: begin
                    if (error_i) begin
                        pc_q      <= spc_i;
                        drain_cnt <= '0;
                        ptr       <= PTR_FIRST;
                    end
                end
                S_HALT: drain_cnt <= drain_cnt + CNT_W'(1);
                S_COPY: begin
                    waddr_q <= ptr;
                    // Pointer parks on the last address instead of wrapping to 0.
                    if (ptr != PTR_LAST) ptr <= ptr + ADDR_WIDTH'(1);
                end
                S_PC: begin
                    if (pc_ack_i && rec_count != 8'hFF) rec_count <= rec_count + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign rf_raddr_o  = ptr;
    assign we_o        = rd_pending;
    assign waddr_o     = waddr_q;
    assign wdata_o     = rd_pending ? rf_rdata_i : wdata_q;
    assign pc_o        = pc_q;
    assign rec_count_o = rec_count;

endmodule

// File: tb/tb_ft_recovery.sv
// Directed bench for ft_recovery: a default instance plus one with SKIP_R0=0, each fed
// by a synchronous-read golden register file preloaded with reg[i]=i*10.
module tb_ft_recovery;

    logic        clk = 1'b0;
    logic        rst;
    logic        err_a, err_b;
    logic [31:0] spc;
    always #5 clk = ~clk;

    // instance A (SKIP_R0=1)
    logic [4:0]  raddr_a, waddr_a;
    logic        re_a, we_a, fb_a, pv_a, ack_a, busy_a;
    logic [31:0] rdata_a, wdata_a, pc_a;
    logic [7:0]  rec_a;
    // instance B (SKIP_R0=0)
    logic [4:0]  raddr_b, waddr_b;
    logic        re_b, we_b, fb_b, pv_b, ack_b, busy_b;
    logic [31:0] rdata_b, wdata_b, pc_b;
    logic [7:0]  rec_b;

    ft_recovery dut_a (
        .clk_i(clk), .rst_i(rst), .error_i(err_a), .spc_i(spc),
        .rf_raddr_o(raddr_a), .rf_re_o(re_a), .rf_rdata_i(rdata_a),
        .we_o(we_a), .waddr_o(waddr_a), .wdata_o(wdata_a), .fetch_block_o(fb_a),
        .pc_o(pc_a), .pc_valid_o(pv_a), .pc_ack_i(ack_a), .busy_o(busy_a),
        .rec_count_o(rec_a)
    );

    ft_recovery #(.SKIP_R0(1'b0)) dut_b (
        .clk_i(clk), .rst_i(rst), .error_i(err_b), .spc_i(spc),
        .rf_raddr_o(raddr_b), .rf_re_o(re_b), .rf_rdata_i(rdata_b),
        .we_o(we_b), .waddr_o(waddr_b), .wdata_o(wdata_b), .fetch_block_o(fb_b),
        .pc_o(pc_b), .pc_valid_o(pv_b), .pc_ack_i(ack_b), .busy_o(busy_b),
        .rec_count_o(rec_b)
    );

    assign ack_b = pv_b;

    logic [31:0] gold [32];
    always @(posedge clk) begin
        if (re_a) rdata_a <= gold[raddr_a];
        if (re_b) rdata_b <= gold[raddr_b];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // free-running cycle index, bumped on every rising edge
    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // pc_ack responder for A: acks after ack_delay cycles of pc_valid
    int ack_delay = 0;
    int vcnt = 0;
    initial begin
        ack_a = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ack_a = 1'b0;
            if (pv_a) begin
                if (vcnt >= ack_delay) ack_a = 1'b1;
                vcnt++;
            end else begin
                vcnt = 0;
            end
        end
    end

    // write/PC monitors
    int          wr_cnt, wr_zero, data_err, order_err, first_we_cyc, starts, acks, pc_bad, pv_cycles;
    logic [4:0]  exp_next, first_addr, last_addr;
    logic [31:0] last_data, pc_seen;
    logic        busy_prev = 1'b0, pv_prev = 1'b0;
    int          wr_cnt_b, data_err_b;
    logic [4:0]  first_addr_b, last_addr_b;
    logic [31:0] first_data_b, last_data_b;

    task automatic clear_log();
        wr_cnt = 0; wr_zero = 0; data_err = 0; order_err = 0; first_we_cyc = -1;
        starts = 0; acks = 0; pc_bad = 0; pv_cycles = 0; exp_next = 5'd1;
        first_addr = '0; last_addr = '0; last_data = '0; pc_seen = '0;
        wr_cnt_b = 0; data_err_b = 0;
    endtask

    initial forever begin
        @(negedge clk);
        if (we_a) begin
            if (first_we_cyc < 0) begin
                first_we_cyc = cyc;
                first_addr   = waddr_a;
            end
            wr_cnt++;
            if (waddr_a == 5'd0) wr_zero++;
            if (wdata_a !== gold[waddr_a]) data_err++;
            if (waddr_a !== exp_next) order_err++;
            exp_next  = (waddr_a == 5'd31) ? 5'd1 : waddr_a + 5'd1;
            last_addr = waddr_a;
            last_data = wdata_a;
        end
        if (busy_a && !busy_prev) starts++;
        busy_prev = busy_a;
        if (pv_a) begin
            pv_cycles++;
            if (pv_prev && pc_a !== pc_seen) pc_bad++;
            if (!fb_a || we_a || re_a) pc_bad++;
            pc_seen = pc_a;
            if (ack_a) acks++;
        end
        pv_prev = pv_a;
        if (we_b) begin
            if (wr_cnt_b == 0) begin
                first_addr_b = waddr_b;
                first_data_b = wdata_b;
            end
            wr_cnt_b++;
            if (wdata_b !== gold[waddr_b]) data_err_b++;
            last_addr_b = waddr_b;
            last_data_b = wdata_b;
        end
    end

    int t, err_cyc, base;
    logic        snap;
    int          starts_snap;
    logic [31:0] pc_snap;

    initial begin
        for (int i = 0; i < 32; i++) gold[i] = 32'(i * 10);
        rst = 1'b1; err_a = 1'b0; err_b = 1'b0; spc = 32'h0;
        clear_log();
        repeat (2) @(negedge clk);
        check("rst_busy", busy_a, 1'b0);
        check("rst_rec", rec_a, 8'd0);
        @(posedge clk); #1 rst = 1'b0;

        // 1: reset in the middle of COPY
        spc = 32'h80; err_a = 1'b1;
        @(posedge clk); #1 err_a = 1'b0;
        t = 0;
        while (!(re_a && raddr_a == 5'd12) && t < 100) begin @(negedge clk); t++; end
        check("t1_reach12", {31'b0, t < 100}, 1);
        rst = 1'b1;
        #1;
        check("t1_fb", fb_a, 1'b0);
        check("t1_busy", busy_a, 1'b0);
        check("t1_re", re_a, 1'b0);
        check("t1_we", we_a, 1'b0);
        check("t1_raddr", raddr_a, 5'd0);
        check("t1_pc", pc_a, 32'h0);
        check("t1_rec", rec_a, 8'd0);
        @(posedge clk); #1 rst = 1'b0;

        // 2: basic recovery, ack 2 cycles after pc_valid
        clear_log();
        ack_delay = 2; spc = 32'h80; err_a = 1'b1; err_cyc = cyc;
        @(posedge clk); #1 err_a = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (busy_a && t < 200);
        check("t2_done", {31'b0, t < 200}, 1);
        check("t2_wr_cnt", wr_cnt, 31);
        check("t2_wr_zero", wr_zero, 0);
        check("t2_data", data_err, 0);
        check("t2_order", order_err, 0);
        check("t2_first", first_addr, 5'd1);
        check("t2_last_a", last_addr, 5'd31);
        check("t2_last_d", last_data, 32'd310);
        check("t2_pc", pc_seen, 32'h80);
        check("t2_pc_hold", pc_bad, 0);
        check("t2_rec", rec_a, 8'd1);
        check("t2_latency", first_we_cyc - err_cyc + 1, 6);
        check("t2_fb_off", fb_a, 1'b0);

        // 3: SKIP_R0=0 copies address 0 too
        clear_log();
        err_b = 1'b1;
        @(posedge clk); #1 err_b = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (busy_b && t < 200);
        check("t3_done", {31'b0, t < 200}, 1);
        check("t3_wr_cnt", wr_cnt_b, 32);
        check("t3_first_a", first_addr_b, 5'd0);
        check("t3_first_d", first_data_b, 32'd0);
        check("t3_last_a", last_addr_b, 5'd31);
        check("t3_last_d", last_data_b, 32'd310);
        check("t3_data", data_err_b, 0);
        check("t3_rec", rec_b, 8'd1);

        // 4: error held 40 cycles, spc changes mid-copy
        clear_log();
        ack_delay = 0; base = rec_a; snap = 1'b0; starts_snap = 0; pc_snap = '0;
        spc = 32'h80; err_a = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (i == 14) spc = 32'h100;
            if (!snap && rec_a == 8'(base + 1)) begin
                snap = 1'b1; starts_snap = starts; pc_snap = pc_seen;
            end
        end
        err_a = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (busy_a && t < 200);
        check("t4_done", {31'b0, t < 200}, 1);
        check("t4_snap", snap, 1'b1);
        check("t4_single", starts_snap, 1);
        check("t4_pc1", pc_snap, 32'h80);
        check("t4_starts", starts, 2);
        check("t4_pc2", pc_seen, 32'h100);
        check("t4_rec", rec_a, 8'(base + 2));
        check("t4_wr_cnt", wr_cnt, 62);
        check("t4_order", order_err, 0);

        // 5: ack withheld 20 cycles, error pulsed while waiting
        clear_log();
        ack_delay = 20; base = rec_a; spc = 32'h44; err_a = 1'b1;
        @(posedge clk); #1 err_a = 1'b0;
        t = 0;
        while (!pv_a && t < 100) begin @(negedge clk); t++; end
        check("t5_pv", pv_a, 1'b1);
        @(posedge clk); #1 err_a = 1'b1;
        repeat (2) @(posedge clk);
        #1 err_a = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (busy_a && t < 200);
        check("t5_done", {31'b0, t < 200}, 1);
        check("t5_pv_cyc", pv_cycles, 21);
        check("t5_stable", pc_bad, 0);
        check("t5_pc", pc_seen, 32'h44);
        check("t5_wr_cnt", wr_cnt, 31);
        check("t5_starts", starts, 1);
        check("t5_rec", rec_a, 8'(base + 1));

        // 6: 257 back-to-back recoveries saturate the counter
        clear_log();
        ack_delay = 0; err_a = 1'b1;
        t = 0;
        while (acks < 257 && t < 20000) begin @(negedge clk); t++; end
        check("t6_acks", {31'b0, acks >= 257}, 1);
        err_a = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (busy_a && t < 200);
        check("t6_done", {31'b0, t < 200}, 1);
        check("t6_rec_sat", rec_a, 8'd255);
        check("t6_order", order_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
